// File: rtl/vga_pixel_driver.sv
`default_nettype none
// ============================================================================
//  Module   : vga_pixel_driver
//  Purpose  : VGA raster generator and DAC pin driver. Publishes pixelX/pixelY
//             to the object mux and re-aligns the mux colour with sync/blank.
//             Optional colour-bar generator is enabled by VGA_TEST_PATTERN_EN.
//  Revision : 1.0  initial release
// ============================================================================
module vga_pixel_driver #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int MUX_LAT  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pixEn,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        testPattern,
`endif
    input  logic [7:0]  redIn,
    input  logic [7:0]  greenIn,
    input  logic [7:0]  blueIn,
    output logic [10:0] pixelX,
    output logic [10:0] pixelY,
    output logic        startOfFrame,
    output logic [7:0]  vgaR,
    output logic [7:0]  vgaG,
    output logic [7:0]  vgaB,
    output logic        vgaHS,
    output logic        vgaVS,
    output logic        vgaBlankN
);

    localparam int          c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [10:0] c_H_LAST  = 11'(c_H_TOTAL - 1);
    localparam logic [10:0] c_V_LAST  = 11'(c_V_TOTAL - 1);
    localparam logic [10:0] c_H_ACT   = 11'(H_ACTIVE);
    localparam logic [10:0] c_V_ACT   = 11'(V_ACTIVE);
    localparam logic [10:0] c_HS_BEG  = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] c_HS_END  = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] c_VS_BEG  = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] c_VS_END  = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Delay-line word: {[bar index,] vs, hs, active}; idle value is blanked, syncs high
`ifdef VGA_TEST_PATTERN_EN
    localparam int c_DW = 6;
`else
    localparam int c_DW = 3;
`endif
    localparam logic [c_DW-1:0] c_DLY_RST = c_DW'(3'b110);

    if (c_H_TOTAL > 2047 || c_V_TOTAL > 2047 || MUX_LAT > 4 || MUX_LAT < 0) begin : g_param_err
        $error("vga_pixel_driver: raster totals must fit 11 bits and MUX_LAT must be 0..4");
    end

    logic [10:0]     r_hCnt;
    logic [10:0]     r_vCnt;
    logic            w_active;
    logic            w_hsRaw;
    logic            w_vsRaw;
    logic [c_DW-1:0] w_dlyIn;
    logic [c_DW-1:0] w_dlyOut;
    logic [7:0]      w_red;
    logic [7:0]      w_green;
    logic [7:0]      w_blue;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hCnt       <= '0;
            r_vCnt       <= '0;
            startOfFrame <= 1'b0;
        end else begin
            startOfFrame <= 1'b0;
            if (pixEn) begin
                if (r_hCnt == c_H_LAST) begin
                    r_hCnt <= '0;
                    if (r_vCnt == c_V_LAST) begin
                        r_vCnt       <= '0;
                        startOfFrame <= 1'b1;
                    end else begin
                        r_vCnt <= r_vCnt + 11'd1;
                    end
                end else begin
                    r_hCnt <= r_hCnt + 11'd1;
                end
            end
        end
    end

    assign pixelX   = r_hCnt;
    assign pixelY   = r_vCnt;
    assign w_active = (r_hCnt < c_H_ACT) && (r_vCnt < c_V_ACT);
    assign w_hsRaw  = !((r_hCnt >= c_HS_BEG) && (r_hCnt < c_HS_END));
    assign w_vsRaw  = !((r_vCnt >= c_VS_BEG) && (r_vCnt < c_VS_END));

`ifdef VGA_TEST_PATTERN_EN
    assign w_dlyIn = {r_hCnt[9:7], w_vsRaw, w_hsRaw, w_active};
`else
    assign w_dlyIn = {w_vsRaw, w_hsRaw, w_active};
`endif

    // Free-running on clk so the alignment tracks the mux, not the pixel rate
    if (MUX_LAT == 0) begin : g_no_dly
        assign w_dlyOut = w_dlyIn;
    end else begin : g_dly
        logic [c_DW-1:0] r_stage [MUX_LAT];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < MUX_LAT; i++) begin
                    r_stage[i] <= c_DLY_RST;
                end
            end else begin
                r_stage[0] <= w_dlyIn;
                for (int i = 1; i < MUX_LAT; i++) begin
                    r_stage[i] <= r_stage[i-1];
                end
            end
        end

        assign w_dlyOut = r_stage[MUX_LAT-1];
    end

    always_comb begin
        w_red   = redIn;
        w_green = greenIn;
        w_blue  = blueIn;
`ifdef VGA_TEST_PATTERN_EN
        if (testPattern) begin
            w_red   = {8{w_dlyOut[5]}};
            w_green = {8{w_dlyOut[4]}};
            w_blue  = {8{w_dlyOut[3]}};
        end
`endif
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vgaR      <= 8'h00;
            vgaG      <= 8'h00;
            vgaB      <= 8'h00;
            vgaHS     <= 1'b1;
            vgaVS     <= 1'b1;
            vgaBlankN <= 1'b0;
        end else begin
            vgaR      <= w_dlyOut[0] ? w_red   : 8'h00;
            vgaG      <= w_dlyOut[0] ? w_green : 8'h00;
            vgaB      <= w_dlyOut[0] ? w_blue  : 8'h00;
            vgaHS     <= w_dlyOut[1];
            vgaVS     <= w_dlyOut[2];
            vgaBlankN <= w_dlyOut[0];
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_pixel_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_pixel_driver
//  Purpose  : Randomised bench for vga_pixel_driver on a reduced raster, with
//             a cycle-level reference model and literal timing checks.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_pixel_driver;

    localparam int HA = 16, HFP = 4, HS = 6, HBP = 6;
    localparam int VA = 10, VFP = 2, VS = 2, VBP = 3;
    localparam int LAT = 1;
    localparam int HT = HA + HFP + HS + HBP;
    localparam int VT = VA + VFP + VS + VBP;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pixEn = 1'b0;
    logic [7:0]  redIn = 8'h00, greenIn = 8'h00, blueIn = 8'h00;
    logic [10:0] pixelX, pixelY;
    logic        startOfFrame;
    logic [7:0]  vgaR, vgaG, vgaB;
    logic        vgaHS, vgaVS, vgaBlankN;
`ifdef VGA_TEST_PATTERN_EN
    logic        testPattern = 1'b0;
`endif

    vga_pixel_driver #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .MUX_LAT(LAT)
    ) dut (
        .clk(clk), .reset(reset), .pixEn(pixEn),
`ifdef VGA_TEST_PATTERN_EN
        .testPattern(testPattern),
`endif
        .redIn(redIn), .greenIn(greenIn), .blueIn(blueIn),
        .pixelX(pixelX), .pixelY(pixelY), .startOfFrame(startOfFrame),
        .vgaR(vgaR), .vgaG(vgaG), .vgaB(vgaB),
        .vgaHS(vgaHS), .vgaVS(vgaVS), .vgaBlankN(vgaBlankN)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_reset_pins(input string tag);
        check({tag, " pixelX"}, int'(pixelX), 0);
        check({tag, " pixelY"}, int'(pixelY), 0);
        check({tag, " sof"}, int'(startOfFrame), 0);
        check({tag, " vgaR"}, int'(vgaR), 0);
        check({tag, " vgaG"}, int'(vgaG), 0);
        check({tag, " vgaB"}, int'(vgaB), 0);
        check({tag, " vgaHS"}, int'(vgaHS), 1);
        check({tag, " vgaVS"}, int'(vgaVS), 1);
        check({tag, " blankN"}, int'(vgaBlankN), 0);
    endtask

    // ---------------- reference model ----------------
    typedef struct {int x; bit act; bit hs; bit vs;} dec_t;

    function automatic dec_t decode(input int x, input int y);
        dec_t d;
        d.x   = x;
        d.act = (x < HA) && (y < VA);
        d.hs  = !((x >= HA + HFP) && (x < HA + HFP + HS));
        d.vs  = !((y >= VA + VFP) && (y < VA + VFP + VS));
        return d;
    endfunction

    dec_t dq[$];
    dec_t d_now;
    dec_t d_idle;
    int   mx, my;
    bit   pe, exp_sof, tp;
    int   idx, er, eg, eb;

    initial begin
        d_idle.x = 0; d_idle.act = 1'b0; d_idle.hs = 1'b1; d_idle.vs = 1'b1;
    end

    // Compare process: inputs are still holding the values the DUT saw at this edge
    always @(posedge clk) begin
        #1;
        if (reset) begin
            check_reset_pins("rst");
            mx = 0;
            my = 0;
            dq.delete();
            for (int i = 0; i < LAT; i++) dq.push_back(d_idle);
            dq.push_back(decode(0, 0));
        end else begin
            pe      = pixEn;
            exp_sof = pe && (mx == HT - 1) && (my == VT - 1);
            if (pe) begin
                mx = (mx + 1) % HT;
                if (mx == 0) my = (my + 1) % VT;
            end
            d_now = dq.pop_front();
            dq.push_back(decode(mx, my));
`ifdef VGA_TEST_PATTERN_EN
            tp = testPattern;
`else
            tp = 1'b0;
`endif
            idx = (d_now.x >> 7) & 7;
            er  = tp ? ((idx & 4) != 0 ? 255 : 0) : int'(redIn);
            eg  = tp ? ((idx & 2) != 0 ? 255 : 0) : int'(greenIn);
            eb  = tp ? ((idx & 1) != 0 ? 255 : 0) : int'(blueIn);
            if (!d_now.act) begin er = 0; eg = 0; eb = 0; end
            check("pixelX", int'(pixelX), mx);
            check("pixelY", int'(pixelY), my);
            check("sof", int'(startOfFrame), int'(exp_sof));
            check("vgaR", int'(vgaR), er);
            check("vgaG", int'(vgaG), eg);
            check("vgaB", int'(vgaB), eb);
            check("vgaHS", int'(vgaHS), int'(d_now.hs));
            check("vgaVS", int'(vgaVS), int'(d_now.vs));
            check("blankN", int'(vgaBlankN), int'(d_now.act));
        end
    end

    // ---------------- stimulus ----------------
    int mode = 0;   // 0: pixEn always, 1: every 2nd clk, 2: random
    int cyc  = 0;

    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
        case (mode)
            0:       pixEn = 1'b1;
            1:       pixEn = cyc[0];
            default: pixEn = 1'($urandom_range(0, 1));
        endcase
        redIn   = 8'($urandom);
        greenIn = 8'($urandom);
        blueIn  = 8'($urandom);
`ifdef VGA_TEST_PATTERN_EN
        testPattern = 1'($urandom_range(0, 1));
`endif
    endtask

    task automatic cycles_to_sof(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!startOfFrame && n < 5000);
    endtask

    function automatic logic sync_pin(input int which);
        return (which != 0) ? vgaVS : vgaHS;
    endfunction

    // Length of the next complete low pulse on HS (which=0) or VS (which=1)
    task automatic low_run(input int which, output int n);
        int guard;
        guard = 0;
        while (sync_pin(which) == 1'b0 && guard < 5000) begin step(); guard++; end
        while (sync_pin(which) == 1'b1 && guard < 5000) begin step(); guard++; end
        n = 0;
        while (sync_pin(which) == 1'b0 && guard < 5000) begin step(); n++; guard++; end
    endtask

    int n;

    initial begin
        #1 reset = 1'b1;
        #2;
        check_reset_pins("async rst");
        repeat (3) @(posedge clk);
        #2;
        mode  = 0;
        pixEn = 1'b1;
        reset = 1'b0;

        cycles_to_sof(n);
        check("first frame clks", n, HT * VT);
        cycles_to_sof(n);
        check("frame period clks", n, HT * VT);
        low_run(0, n);
        check("hsync width full rate", n, HS);
        low_run(1, n);
        check("vsync width clks", n, VS * HT);

        mode = 1;
        low_run(0, n);
        check("hsync width half rate", n, 2 * HS);
        repeat (2 * HT * VT) step();

        mode = 2;
        n = 0;
        do begin step(); n++; end
        while (!(pixelX == 11'd7 && pixelY == 11'd3) && n < 5000);
        check("reach (7,3)", int'(pixelX) * 100 + int'(pixelY), 703);
        #3 reset = 1'b1;
        #1;
        check_reset_pins("mid-frame rst");
        repeat (2) @(posedge clk);
        #2;
        mode  = 0;
        pixEn = 1'b1;
        reset = 1'b0;
        cycles_to_sof(n);
        check("frame after reset clks", n, HT * VT);

        mode = 2;
        repeat (3000) step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
